// File: rtl/uart_load_pkg.sv
// ---------------------------------------------------------------------------
// uart_load_pkg
//   Shared definitions for the UART program-load controller:
//     - load_state_t : controller state, encoded exactly as the load_state port
//     - address field positions used to decode a received byte address
//     - addr_ok()    : alignment / range check for a received byte address
// ---------------------------------------------------------------------------
package uart_load_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_RELEASE = 2'd3
    } load_state_t;

    // Byte-address fields of a received word
    localparam int SEL_BIT   = 16;  // 0 = imem, 1 = dmem
    localparam int ALIGN_HI  = 1;
    localparam int ALIGN_LO  = 0;
    localparam int RANGE_HI  = 31;
    localparam int RANGE_LO  = 17;

    // DRAIN covers the synchronizer + event-register depth so a toggle
    // already in flight when done arrives is still written.
    localparam int DRAIN_CYC = 3;

    // A received address is usable only if word aligned and inside the
    // two 64 KiB windows (imem / dmem).
    function automatic logic addr_ok(input logic [31:0] a);
        return (~|a[ALIGN_HI:ALIGN_LO]) && (~|a[RANGE_HI:RANGE_LO]);
    endfunction

endpackage

// File: rtl/uart_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_load_ctrl_if
//   Single-cycle memory write port (write enable, word address, data).
//   master : drives the port (controller -> imem / dmem)
//   slave  : observes the port (CPU -> controller)
// ---------------------------------------------------------------------------
interface uart_load_ctrl_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    modport master (output we, output addr, output wdata);
    modport slave  (input  we, input  addr, input  wdata);
endinterface

// File: rtl/uart_load_ctrl_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
//   Two-flop synchronizer for an asynchronous level, followed by a register
//   holding the previous synchronized value for edge detection.
//   Ports:
//     fpga_clk  in  system clock
//     reset_n   in  synchronous, active-low reset
//     async_in  in  signal from another clock domain / a switch
//     level     out synchronized level
//     rise      out one-cycle pulse on a 0->1 change of level
//     any_edge  out one-cycle pulse on any change of level
// ---------------------------------------------------------------------------
module sync_edge (
    input  logic fpga_clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic any_edge
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge fpga_clk) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level    = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign any_edge = sync_q ^ prev_q;

endmodule

// File: rtl/uart_load_ctrl.sv
// ---------------------------------------------------------------------------
// uart_load_ctrl
//   Sequences UART program loading. While a load runs the CPU is held in
//   reset and received words are written to imem or dmem; outside a load
//   the CPU owns the dmem write port (combinational passthrough).
//   Ports:
//     fpga_clk, reset_n   clock, synchronous active-low reset
//     mode_sw             load-mode request switch (async)
//     uart_wtoggle        flips once per received word (upg_clk domain)
//     uart_addr/data      received byte address / word
//     uart_done           transfer finished level (upg_clk domain)
//     cpu_dmem  (slave)   CPU data-memory write port
//     imem      (master)  instruction-memory write port
//     dmem      (master)  data-memory write port
//     cpu_rst_n           CPU reset, active low
//     loaded_words        words accepted in current/last load (saturating)
//     load_state          RUN=0 LOAD=1 DRAIN=2 RELEASE=3
//     err_addr            sticky: a write was dropped for a bad address
// ---------------------------------------------------------------------------
module uart_load_ctrl
    import uart_load_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 32,
    parameter int RELEASE_CYC = 4
) (
    input  logic               fpga_clk,
    input  logic               reset_n,
    input  logic               mode_sw,
    input  logic               uart_wtoggle,
    input  logic [31:0]        uart_addr,
    input  logic [DATA_W-1:0]  uart_data,
    input  logic               uart_done,
    uart_load_ctrl_if.slave    cpu_dmem,
    uart_load_ctrl_if.master   imem,
    uart_load_ctrl_if.master   dmem,
    output logic               cpu_rst_n,
    output logic [15:0]        loaded_words,
    output logic [1:0]         load_state,
    output logic               err_addr
);

    localparam int CNT_W = $clog2(RELEASE_CYC + DRAIN_CYC + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(RELEASE_CYC - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    // Synchronizers (run in every state)
    logic mode_lvl, mode_rise_unused, mode_edge_unused;
    logic tog_lvl_unused, tog_rise_unused, tog_any;
    logic done_lvl_unused, done_rise, done_edge_unused;

    sync_edge u_sync_mode (
        .fpga_clk (fpga_clk),
        .reset_n  (reset_n),
        .async_in (mode_sw),
        .level    (mode_lvl),
        .rise     (mode_rise_unused),
        .any_edge (mode_edge_unused)
    );

    sync_edge u_sync_tog (
        .fpga_clk (fpga_clk),
        .reset_n  (reset_n),
        .async_in (uart_wtoggle),
        .level    (tog_lvl_unused),
        .rise     (tog_rise_unused),
        .any_edge (tog_any)
    );

    sync_edge u_sync_done (
        .fpga_clk (fpga_clk),
        .reset_n  (reset_n),
        .async_in (uart_done),
        .level    (done_lvl_unused),
        .rise     (done_rise),
        .any_edge (done_edge_unused)
    );

    // Stage p0: register events, capture received word on the toggle edge
    logic              vld_p0;
    logic              done_ev_p0;
    logic [31:0]       addr_p0;
    logic [DATA_W-1:0] data_p0;

    always_ff @(posedge fpga_clk) begin
        if (!reset_n) begin
            vld_p0     <= 1'b0;
            done_ev_p0 <= 1'b0;
            addr_p0    <= '0;
            data_p0    <= '0;
        end else begin
            vld_p0     <= tog_any;
            done_ev_p0 <= done_rise;
            if (tog_any) begin
                addr_p0 <= uart_addr;
                data_p0 <= uart_data;
            end
        end
    end

    // Control FSM
    load_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clear_stats;

    always_ff @(posedge fpga_clk) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clear_stats = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mode_lvl) begin
                    state_d     = ST_LOAD;
                    clear_stats = 1'b1;
                end
            end
            ST_LOAD: begin
                if (done_ev_p0) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                // Counter parks at REL_LAST while the switch keeps us here
                if (cnt_q == REL_LAST) begin
                    if (!mode_lvl) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // CPU reset lags the state by one cycle: low from the cycle after LOAD
    // is entered until the cycle after RUN is re-entered.
    always_ff @(posedge fpga_clk) begin
        if (!reset_n) begin
            cpu_rst_n <= 1'b0;
        end else begin
            cpu_rst_n <= (state_q == ST_RUN);
        end
    end

    logic in_load;
    logic accept;
    logic drop;

    assign in_load = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign accept  = vld_p0 && in_load && addr_ok(addr_p0);
    assign drop    = vld_p0 && in_load && !addr_ok(addr_p0);

    // Stage p1: decode and issue the one-cycle memory write
    logic              imem_we_p1;
    logic              dmem_we_p1;
    logic [ADDR_W-1:0] waddr_p1;
    logic [DATA_W-1:0] wdata_p1;

    always_ff @(posedge fpga_clk) begin
        if (!reset_n) begin
            imem_we_p1   <= 1'b0;
            dmem_we_p1   <= 1'b0;
            waddr_p1     <= '0;
            wdata_p1     <= '0;
            loaded_words <= '0;
            err_addr     <= 1'b0;
        end else begin
            imem_we_p1 <= accept && !addr_p0[SEL_BIT];
            dmem_we_p1 <= accept &&  addr_p0[SEL_BIT];
            if (accept) begin
                waddr_p1 <= addr_p0[ADDR_W+1:2];
                wdata_p1 <= data_p0;
            end
            if (clear_stats) begin
                loaded_words <= '0;
                err_addr     <= 1'b0;
            end else begin
                if (accept) begin
                    loaded_words <= sat_inc(loaded_words);
                end
                if (drop) begin
                    err_addr <= 1'b1;
                end
            end
        end
    end

    // Output ports: imem is only ever written by the loader; dmem belongs
    // to the CPU in RUN (gated by reset) and to the loader otherwise.
    logic run_mode;
    assign run_mode = (state_q == ST_RUN);

    assign imem.we    = imem_we_p1;
    assign imem.addr  = waddr_p1;
    assign imem.wdata = wdata_p1;

    assign dmem.we    = run_mode ? (cpu_dmem.we & reset_n) : dmem_we_p1;
    assign dmem.addr  = run_mode ? cpu_dmem.addr  : waddr_p1;
    assign dmem.wdata = run_mode ? cpu_dmem.wdata : wdata_p1;

    assign load_state = state_q;

endmodule

// File: tb/tb_uart_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_load_ctrl
//   Directed bench for uart_load_ctrl. Inputs change and outputs are
//   sampled 1 time unit after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_uart_load_ctrl;

    localparam int ADDR_W      = 14;
    localparam int DATA_W      = 32;
    localparam int RELEASE_CYC = 4;

    logic        fpga_clk = 1'b0;
    logic        reset_n;
    logic        mode_sw;
    logic        uart_wtoggle;
    logic [31:0] uart_addr;
    logic [31:0] uart_data;
    logic        uart_done;
    logic        cpu_rst_n;
    logic [15:0] loaded_words;
    logic [1:0]  load_state;
    logic        err_addr;

    int n_cmp = 0;
    int n_err = 0;

    uart_load_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();
    uart_load_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) imem_if ();
    uart_load_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dmem_if ();

    uart_load_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .RELEASE_CYC (RELEASE_CYC)
    ) dut (
        .fpga_clk     (fpga_clk),
        .reset_n      (reset_n),
        .mode_sw      (mode_sw),
        .uart_wtoggle (uart_wtoggle),
        .uart_addr    (uart_addr),
        .uart_data    (uart_data),
        .uart_done    (uart_done),
        .cpu_dmem     (cpu_if.slave),
        .imem         (imem_if.master),
        .dmem         (dmem_if.master),
        .cpu_rst_n    (cpu_rst_n),
        .loaded_words (loaded_words),
        .load_state   (load_state),
        .err_addr     (err_addr)
    );

    always #5 fpga_clk = ~fpga_clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fpga_clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] a, input logic [31:0] d);
        uart_addr    = a;
        uart_data    = d;
        uart_wtoggle = ~uart_wtoggle;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        mode_sw      = 1'b0;
        uart_wtoggle = 1'b0;
        uart_done    = 1'b0;
        uart_addr    = '0;
        uart_data    = '0;
        cpu_if.we    = 1'b1;
        cpu_if.addr  = 14'h3;
        cpu_if.wdata = 32'h1111;
        tick(3);
        n_cmp++; if (load_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", load_state); end
        n_cmp++; if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_cpu_rst_n: got %b want 0", cpu_rst_n); end
        n_cmp++; if (imem_if.we !== 1'b0) begin n_err++; $display("FAIL rst_imem_we: got %b want 0", imem_if.we); end
        n_cmp++; if (dmem_if.we !== 1'b0) begin n_err++; $display("FAIL rst_dmem_we: got %b want 0", dmem_if.we); end
        n_cmp++; if (loaded_words !== 16'd0) begin n_err++; $display("FAIL rst_loaded: got %h want 0", loaded_words); end
        n_cmp++; if (err_addr !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err_addr); end
        n_cmp++; if (imem_if.addr !== 14'd0) begin n_err++; $display("FAIL rst_imem_addr: got %h want 0", imem_if.addr); end
        n_cmp++; if (imem_if.wdata !== 32'd0) begin n_err++; $display("FAIL rst_imem_wdata: got %h want 0", imem_if.wdata); end
        reset_n = 1'b1;
        tick(1);
        n_cmp++; if (cpu_rst_n !== 1'b1) begin n_err++; $display("FAIL rel_cpu_rst_n: got %b want 1", cpu_rst_n); end
        n_cmp++; if (dmem_if.we !== 1'b1) begin n_err++; $display("FAIL rel_dmem_we: got %b want 1", dmem_if.we); end
        cpu_if.we = 1'b0;
    endtask

    task automatic test_run_passthrough();
        logic seen;
        cpu_if.we    = 1'b1;
        cpu_if.addr  = 14'd5;
        cpu_if.wdata = 32'hA5A5_A5A5;
        #1;
        n_cmp++; if (dmem_if.we !== 1'b1) begin n_err++; $display("FAIL run_dmem_we: got %b want 1", dmem_if.we); end
        n_cmp++; if (dmem_if.addr !== 14'd5) begin n_err++; $display("FAIL run_dmem_addr: got %h want 5", dmem_if.addr); end
        n_cmp++; if (dmem_if.wdata !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL run_dmem_wdata: got %h want a5a5a5a5", dmem_if.wdata); end
        cpu_if.we = 1'b0;
        tick(1);
        push_word(32'h0, 32'h55);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (imem_if.we !== 1'b0 || dmem_if.we !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL run_toggle_write: got %b want 0", seen); end
        n_cmp++; if (loaded_words !== 16'd0) begin n_err++; $display("FAIL run_toggle_loaded: got %h want 0", loaded_words); end
    endtask

    task automatic test_mode_entry();
        mode_sw = 1'b1;
        tick(2);
        n_cmp++; if (load_state !== 2'd0) begin n_err++; $display("FAIL entry_early: got %0d want 0", load_state); end
        tick(1);
        n_cmp++; if (load_state !== 2'd1) begin n_err++; $display("FAIL entry_state: got %0d want 1", load_state); end
        n_cmp++; if (cpu_rst_n !== 1'b1) begin n_err++; $display("FAIL entry_rst_lag: got %b want 1", cpu_rst_n); end
        tick(1);
        n_cmp++; if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL entry_rst_low: got %b want 0", cpu_rst_n); end
        n_cmp++; if (loaded_words !== 16'd0) begin n_err++; $display("FAIL entry_loaded_clr: got %h want 0", loaded_words); end
        n_cmp++; if (err_addr !== 1'b0) begin n_err++; $display("FAIL entry_err_clr: got %b want 0", err_addr); end
    endtask

    task automatic test_load_imem();
        cpu_if.we    = 1'b1;
        cpu_if.addr  = 14'd7;
        cpu_if.wdata = 32'hFFFF_0000;
        push_word(32'h0000_0000, 32'hDEAD_BEEF);
        tick(3);
        n_cmp++; if (imem_if.we !== 1'b0) begin n_err++; $display("FAIL w0_early: got %b want 0", imem_if.we); end
        n_cmp++; if (dmem_if.we !== 1'b0) begin n_err++; $display("FAIL load_cpu_discard: got %b want 0", dmem_if.we); end
        tick(1);
        n_cmp++; if (imem_if.we !== 1'b1) begin n_err++; $display("FAIL w0_we: got %b want 1", imem_if.we); end
        n_cmp++; if (imem_if.addr !== 14'd0) begin n_err++; $display("FAIL w0_addr: got %h want 0", imem_if.addr); end
        n_cmp++; if (imem_if.wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL w0_data: got %h want deadbeef", imem_if.wdata); end
        n_cmp++; if (loaded_words !== 16'd1) begin n_err++; $display("FAIL w0_loaded: got %h want 1", loaded_words); end
        n_cmp++; if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL w0_cpu_rst_n: got %b want 0", cpu_rst_n); end
        tick(1);
        n_cmp++; if (imem_if.we !== 1'b0) begin n_err++; $display("FAIL w0_pulse_len: got %b want 0", imem_if.we); end
        push_word(32'h0000_0004, 32'h1234_5678);
        tick(4);
        n_cmp++; if (imem_if.we !== 1'b1) begin n_err++; $display("FAIL w1_we: got %b want 1", imem_if.we); end
        n_cmp++; if (imem_if.addr !== 14'd1) begin n_err++; $display("FAIL w1_addr: got %h want 1", imem_if.addr); end
        n_cmp++; if (imem_if.wdata !== 32'h1234_5678) begin n_err++; $display("FAIL w1_data: got %h want 12345678", imem_if.wdata); end
        n_cmp++; if (loaded_words !== 16'd2) begin n_err++; $display("FAIL w1_loaded: got %h want 2", loaded_words); end
        n_cmp++; if (dmem_if.we !== 1'b0) begin n_err++; $display("FAIL w1_dmem_we: got %b want 0", dmem_if.we); end
        tick(1);
        cpu_if.we = 1'b0;
    endtask

    task automatic test_dmem_err();
        push_word(32'h0001_0008, 32'hCAFE_F00D);
        tick(4);
        n_cmp++; if (dmem_if.we !== 1'b1) begin n_err++; $display("FAIL d_we: got %b want 1", dmem_if.we); end
        n_cmp++; if (dmem_if.addr !== 14'd2) begin n_err++; $display("FAIL d_addr: got %h want 2", dmem_if.addr); end
        n_cmp++; if (dmem_if.wdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL d_data: got %h want cafef00d", dmem_if.wdata); end
        n_cmp++; if (imem_if.we !== 1'b0) begin n_err++; $display("FAIL d_imem_we: got %b want 0", imem_if.we); end
        n_cmp++; if (loaded_words !== 16'd3) begin n_err++; $display("FAIL d_loaded: got %h want 3", loaded_words); end
        n_cmp++; if (err_addr !== 1'b0) begin n_err++; $display("FAIL d_err: got %b want 0", err_addr); end
        tick(1);
        push_word(32'h0000_0006, 32'h0000_0001);
        tick(4);
        n_cmp++; if ((imem_if.we | dmem_if.we) !== 1'b0) begin n_err++; $display("FAIL mis_we: got %b want 0", imem_if.we | dmem_if.we); end
        n_cmp++; if (err_addr !== 1'b1) begin n_err++; $display("FAIL mis_err: got %b want 1", err_addr); end
        n_cmp++; if (loaded_words !== 16'd3) begin n_err++; $display("FAIL mis_loaded: got %h want 3", loaded_words); end
        tick(1);
        push_word(32'h0002_0000, 32'h0000_0002);
        tick(4);
        n_cmp++; if ((imem_if.we | dmem_if.we) !== 1'b0) begin n_err++; $display("FAIL rng_we: got %b want 0", imem_if.we | dmem_if.we); end
        n_cmp++; if (loaded_words !== 16'd3) begin n_err++; $display("FAIL rng_loaded: got %h want 3", loaded_words); end
        tick(1);
    endtask

    task automatic test_done_seq();
        uart_done = 1'b1;                       // cycle k
        tick(1);
        push_word(32'h0000_0010, 32'h0BAD_F00D); // cycle k+1
        tick(2);
        n_cmp++; if (load_state !== 2'd1) begin n_err++; $display("FAIL ds_k3: got %0d want 1", load_state); end
        tick(1);
        n_cmp++; if (load_state !== 2'd2) begin n_err++; $display("FAIL ds_drain: got %0d want 2", load_state); end
        tick(1);
        n_cmp++; if (imem_if.we !== 1'b1) begin n_err++; $display("FAIL ds_we: got %b want 1", imem_if.we); end
        n_cmp++; if (imem_if.addr !== 14'd4) begin n_err++; $display("FAIL ds_addr: got %h want 4", imem_if.addr); end
        n_cmp++; if (imem_if.wdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL ds_data: got %h want 0badf00d", imem_if.wdata); end
        n_cmp++; if (loaded_words !== 16'd4) begin n_err++; $display("FAIL ds_loaded: got %h want 4", loaded_words); end
        tick(1);
        n_cmp++; if (load_state !== 2'd2) begin n_err++; $display("FAIL ds_drain_end: got %0d want 2", load_state); end
        tick(1);
        n_cmp++; if (load_state !== 2'd3) begin n_err++; $display("FAIL ds_release: got %0d want 3", load_state); end
        tick(7);
        n_cmp++; if (load_state !== 2'd3) begin n_err++; $display("FAIL ds_hold: got %0d want 3", load_state); end
        n_cmp++; if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL ds_hold_rst: got %b want 0", cpu_rst_n); end
        mode_sw = 1'b0;                         // cycle k+14
        tick(2);
        n_cmp++; if (load_state !== 2'd3) begin n_err++; $display("FAIL ds_sw_sync: got %0d want 3", load_state); end
        tick(1);
        n_cmp++; if (load_state !== 2'd0) begin n_err++; $display("FAIL ds_run: got %0d want 0", load_state); end
        n_cmp++; if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL ds_run_rst_lag: got %b want 0", cpu_rst_n); end
        tick(1);
        n_cmp++; if (cpu_rst_n !== 1'b1) begin n_err++; $display("FAIL ds_run_rst: got %b want 1", cpu_rst_n); end
        uart_done = 1'b0;
        tick(3);
    endtask

    task automatic test_release_min();
        test_mode_entry();
        mode_sw = 1'b0;
        tick(2);
        uart_done = 1'b1;                       // cycle k
        tick(3);
        n_cmp++; if (load_state !== 2'd1) begin n_err++; $display("FAIL rm_load: got %0d want 1", load_state); end
        tick(1);
        n_cmp++; if (load_state !== 2'd2) begin n_err++; $display("FAIL rm_drain: got %0d want 2", load_state); end
        tick(3);
        n_cmp++; if (load_state !== 2'd3) begin n_err++; $display("FAIL rm_release: got %0d want 3", load_state); end
        tick(3);
        n_cmp++; if (load_state !== 2'd3) begin n_err++; $display("FAIL rm_release_last: got %0d want 3", load_state); end
        tick(1);
        n_cmp++; if (load_state !== 2'd0) begin n_err++; $display("FAIL rm_run: got %0d want 0", load_state); end
        uart_done = 1'b0;
        tick(3);
    endtask

    task automatic test_reset_mid_load();
        test_mode_entry();
        push_word(32'h0000_0008, 32'h0000_0077);
        tick(4);
        n_cmp++; if (imem_if.we !== 1'b1) begin n_err++; $display("FAIL ml_first_we: got %b want 1", imem_if.we); end
        n_cmp++; if (loaded_words !== 16'd1) begin n_err++; $display("FAIL ml_first_loaded: got %h want 1", loaded_words); end
        tick(1);
        push_word(32'h0000_000C, 32'h0000_0088);
        tick(3);                                // tog_ev high now
        reset_n = 1'b0;
        mode_sw = 1'b0;
        tick(1);
        n_cmp++; if ((imem_if.we | dmem_if.we) !== 1'b0) begin n_err++; $display("FAIL ml_abort_we: got %b want 0", imem_if.we | dmem_if.we); end
        n_cmp++; if (load_state !== 2'd0) begin n_err++; $display("FAIL ml_state: got %0d want 0", load_state); end
        n_cmp++; if (loaded_words !== 16'd0) begin n_err++; $display("FAIL ml_loaded: got %h want 0", loaded_words); end
        n_cmp++; if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL ml_rst_low: got %b want 0", cpu_rst_n); end
        reset_n = 1'b1;
        tick(1);
        n_cmp++; if (cpu_rst_n !== 1'b1) begin n_err++; $display("FAIL ml_rst_high: got %b want 1", cpu_rst_n); end
        n_cmp++; if (imem_if.we !== 1'b0) begin n_err++; $display("FAIL ml_post_we: got %b want 0", imem_if.we); end
        tick(3);
    endtask

    task automatic test_saturation();
        test_mode_entry();
        for (int i = 0; i < 65534; i++) begin
            push_word(32'h0, i);
            tick(1);
        end
        tick(5);
        n_cmp++; if (loaded_words !== 16'hFFFE) begin n_err++; $display("FAIL sat_fffe: got %h want fffe", loaded_words); end
        for (int i = 0; i < 3; i++) begin
            push_word(32'h0, i);
            tick(1);
        end
        tick(5);
        n_cmp++; if (loaded_words !== 16'hFFFF) begin n_err++; $display("FAIL sat_ffff: got %h want ffff", loaded_words); end
        n_cmp++; if (err_addr !== 1'b0) begin n_err++; $display("FAIL sat_err: got %b want 0", err_addr); end
    endtask

    initial begin
        test_reset();
        test_run_passthrough();
        test_mode_entry();
        test_load_imem();
        test_dmem_err();
        test_done_seq();
        test_release_min();
        test_reset_mid_load();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
